// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - receive-side output bundle of the UART frame receiver
// Signals:
//   P_DATA       last good payload, LSB received first
//   Data_Valid   one-cycle pulse, P_DATA is new
//   Parity_Error one-cycle pulse, received parity bit mismatched
//   Stop_Error   one-cycle pulse, stop bit sampled 0
//   Busy         high while a frame is in progress
// Modports: master = receiver (drives), slave = consumer (observes).
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Parity_Error;
    logic                  Stop_Error;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output Parity_Error,
        output Stop_Error,
        output Busy
    );

    modport slave (
        input P_DATA,
        input Data_Valid,
        input Parity_Error,
        input Stop_Error,
        input Busy
    );
endinterface

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling UART receiver, serial frame to parallel word
// Optional feature macro: UART_RX_MAJORITY_SAMPLE_EN
//   defined   : bit value is the 2-of-3 majority of samples at Prescale/2-1, /2, /2+1
//   undefined : bit value is the single sample at Prescale/2
//   Decision timing and latency are identical in both builds.
// Ports:
//   CLK      RX oversampling clock (Prescale x baud), rising edge
//   RST      asynchronous active-high reset
//   RX_IN    synchronised serial line, idles high
//   PAR_EN   frame carries a parity bit (latched at start detect)
//   PAR_TYP  0 = even, 1 = odd parity (latched at start detect)
//   Prescale oversampling ratio 8/16/32 (latched at start detect)
//   rx_bus   uart_rx_frame_if.master: P_DATA, Data_Valid, Parity_Error, Stop_Error, Busy
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            RX_IN,
    input  logic            PAR_EN,
    input  logic            PAR_TYP,
    input  logic [5:0]      Prescale,
    uart_rx_frame_if.master rx_bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                state;
    logic [5:0]            edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [5:0]            pres_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_err;
    logic                  stop_err;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  stop_error;
    logic                  busy;
    logic                  smp_mid;
    logic                  sampled;
    logic                  vote;

    logic [5:0]            mid;
    logic [5:0]            mid_p1;
    logic [5:0]            last_edge;
    logic                  bit_end;
    logic                  par_expect;

    assign mid       = pres_q >> 1;
    assign mid_p1    = mid + 6'd1;
    assign last_edge = pres_q - 6'd1;
    assign bit_end   = (edge_cnt == last_edge);
    assign par_expect = par_typ_q ? ~^shift : ^shift;

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic       smp_early;
    logic [5:0] mid_m1;
    assign mid_m1 = mid - 6'd1;
    // Third vote is the live line at Prescale/2+1, the same edge the result is registered.
    assign vote = (smp_early & smp_mid) | (smp_early & RX_IN) | (smp_mid & RX_IN);
`else
    assign vote = smp_mid;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            pres_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
            shift        <= '0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            busy         <= 1'b0;
            smp_mid      <= 1'b1;
            sampled      <= 1'b1;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
            smp_early    <= 1'b1;
`endif
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            // Mid-bit sampling runs in every bit-timed state.
            if (state != IDLE && state != DONE) begin
`ifdef UART_RX_MAJORITY_SAMPLE_EN
                if (edge_cnt == mid_m1) smp_early <= RX_IN;
`endif
                if (edge_cnt == mid)    smp_mid   <= RX_IN;
                if (edge_cnt == mid_p1) sampled   <= vote;
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
            end

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state     <= START;
                        edge_cnt  <= '0;
                        bit_cnt   <= '0;
                        pres_q    <= Prescale;
                        par_en_q  <= PAR_EN;
                        par_typ_q <= PAR_TYP;
                        par_err   <= 1'b0;
                        stop_err  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        if (sampled) begin
                            // Line was back high at mid-bit: a glitch, not a start bit.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        shift   <= {sampled, shift[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        par_err <= (sampled != par_expect);
                        state   <= STOP;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        stop_err <= !sampled;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    parity_error <= par_err;
                    stop_error   <= stop_err;
                    if (!par_err && !stop_err) begin
                        p_data     <= shift;
                        data_valid <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.P_DATA       = p_data;
    assign rx_bus.Data_Valid   = data_valid;
    assign rx_bus.Parity_Error = parity_error;
    assign rx_bus.Stop_Error   = stop_error;
    assign rx_bus.Busy         = busy;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame
module tb_uart_rx_frame;
    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;

    uart_rx_frame_if #(.DATA_WIDTH(8)) rx_bus ();

    uart_rx_frame #(.DATA_WIDTH(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .Prescale (Prescale),
        .rx_bus   (rx_bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int dv_cnt, pe_cnt, se_cnt, busy_cnt, first_cyc, start_cyc;
    int checks = 0;
    int errors = 0;

    always @(negedge CLK) begin
        if (rx_bus.Data_Valid) begin
            dv_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (rx_bus.Parity_Error) begin
            pe_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (rx_bus.Stop_Error) begin
            se_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (rx_bus.Busy) busy_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        int         pres;
        bit         par_en;
        bit         par_typ;
        bit         pbit;
        bit         sbit;
        bit         glitch;
        int         exp_dv;
        int         exp_pe;
        int         exp_se;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clear_mon();
        dv_cnt    = 0;
        pe_cnt    = 0;
        se_cnt    = 0;
        busy_cnt  = 0;
        first_cyc = -1;
    endtask

    // Drives one frame bit-by-bit. abort_b >= 0 pulses RST at mid-bit of that frame bit.
    task automatic run_vec(input vec_t v, input int id, input int abort_b);
        logic [11:0] bits;
        int n, p, mid;
        p    = v.pres;
        mid  = p / 2;
        bits = '1;
        bits[0]   = 1'b0;
        bits[8:1] = v.data;
        if (v.par_en) begin
            bits[9]  = v.pbit;
            bits[10] = v.sbit;
            n = 11;
        end else begin
            bits[9] = v.sbit;
            n = 10;
        end
        PAR_EN   = v.par_en;
        PAR_TYP  = v.par_typ;
        Prescale = 6'(p);
        clear_mon();
        @(posedge CLK); #1;
        RX_IN     = 1'b0;
        start_cyc = cyc + 1;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < p; c++) begin
                @(posedge CLK); #1;
                if (c == 0) RX_IN = bits[b];
                if (b == 0 && c == 0) begin
                    // Config changes mid-frame must be ignored.
                    PAR_EN   = ~v.par_en;
                    PAR_TYP  = ~v.par_typ;
                    Prescale = (p == 8) ? 6'd16 : 6'd8;
                end
                if (v.glitch && b >= 1 && b <= 8) begin
                    if (c == mid)          RX_IN = ~bits[b];
                    else if (c == mid + 1) RX_IN = bits[b];
                end
                if (b == abort_b && c == mid) begin
                    RST = 1'b1;
                    #2;
                    chk($sformatf("rst_async_pdata_v%0d", id), int'(rx_bus.P_DATA), 0);
                    chk($sformatf("rst_async_busy_v%0d", id), int'(rx_bus.Busy), 0);
                    @(posedge CLK); #1;
                    chk($sformatf("rst_edge_outs_v%0d", id),
                        int'({rx_bus.P_DATA, rx_bus.Data_Valid, rx_bus.Parity_Error,
                              rx_bus.Stop_Error, rx_bus.Busy}), 0);
                    RST   = 1'b0;
                    RX_IN = 1'b1;
                    repeat (3 * p) @(posedge CLK);
                    #1;
                    chk($sformatf("rst_no_pulses_v%0d", id), dv_cnt + pe_cnt + se_cnt, 0);
                    chk($sformatf("rst_idle_busy_v%0d", id), int'(rx_bus.Busy), 0);
                    return;
                end
            end
        end
        @(posedge CLK); #1;
        RX_IN = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        chk($sformatf("dv_cnt_v%0d", id), dv_cnt, v.exp_dv);
        chk($sformatf("pe_cnt_v%0d", id), pe_cnt, v.exp_pe);
        chk($sformatf("se_cnt_v%0d", id), se_cnt, v.exp_se);
        chk($sformatf("p_data_v%0d", id), int'(rx_bus.P_DATA), int'(v.exp_data));
        chk($sformatf("latency_v%0d", id), first_cyc - start_cyc, n * p + 1);
        chk($sformatf("busy_cycles_v%0d", id), busy_cnt, n * p + 1);
        chk($sformatf("busy_after_v%0d", id), int'(rx_bus.Busy), 0);
    endtask

    logic [7:0] glitch_exp;

    initial begin
`ifdef UART_RX_MAJORITY_SAMPLE_EN
        glitch_exp = 8'h55;
`else
        glitch_exp = 8'hAA;
`endif
        //          data   pres par_en par_typ pbit  sbit  glitch dv pe se exp_data
        vecs[0] = '{8'hA5,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h3C};
        vecs[2] = '{8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 0, 8'h3C};
        vecs[3] = '{8'h01, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h3C};
        vecs[4] = '{8'h7E, 32, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 0, 8'h7E};
        vecs[5] = '{8'h0F,  8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1, 8'h7E};
        vecs[6] = '{8'h80,  8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'h80};
        vecs[7] = '{8'h55,  8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 0, glitch_exp};

        RST      = 1'b1;
        RX_IN    = 1'b1;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        Prescale = 6'd8;
        clear_mon();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs",
            int'({rx_bus.P_DATA, rx_bus.Data_Valid, rx_bus.Parity_Error,
                  rx_bus.Stop_Error, rx_bus.Busy}), 0);
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        chk("idle_busy", int'(rx_bus.Busy), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i, -1);

        // Start glitch: line low for 2 cycles at Prescale=8.
        PAR_EN   = 1'b0;
        Prescale = 6'd8;
        clear_mon();
        @(posedge CLK); #1;
        RX_IN = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RX_IN = 1'b1;
        repeat (16) @(posedge CLK);
        #1;
        chk("glitch_busy_cycles", busy_cnt, 8);
        chk("glitch_no_pulses", dv_cnt + pe_cnt + se_cnt, 0);
        chk("glitch_pdata_held", int'(rx_bus.P_DATA), int'(glitch_exp));

        // Reset during DATA bit 4 (frame bit 5), then a clean frame.
        run_vec('{8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 8'h00}, 8, 5);
        run_vec('{8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0, 0, 8'hC3}, 9, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
